fifo_write_scheduler: RTL
=========================

# fifo_write_scheduler

Write-side scheduler for the two-entry asynchronous word FIFO. It sits in the FIFO write clock domain between THREADS producer threads and the FIFO write port. It packs non-overlapping word requests from several threads into one FIFO entry, shares entries between threads by round-robin, and tracks FIFO occupancy with a credit counter so no entry is overwritten.

## Interface
Parameters:
- WORDS, 2, words per FIFO entry
- THREADS, 3, number of producer threads
- CREDITS, 2, FIFO entries available at reset; must equal FIFO depth

Ports:
- i_clk  in  1  FIFO write clock
- i_rst  in  1  reset, asynchronous, active-high
- i_req  in  [THREADS-1:0]  per-thread request, held until granted
- i_req_mask  in  [WORDS-1:0] x [THREADS-1:0]  words the thread writes; stable while i_req is high
- i_credit_return  in  1  one-cycle pulse per entry pulled by the reader, already synchronized to i_clk
- o_grant  out  [THREADS-1:0]  one-cycle grant pulse per thread
- o_w_push  out  1  FIFO push strobe
- o_w_enables  out  [THREADS-1:0] x [WORDS-1:0]  per-word thread enables for the FIFO
- o_credits  out  $clog2(CREDITS+1)  free entries
- o_err  out  1  sticky protocol error

## Operation
- Eligible thread: i_req high, o_grant bit low this cycle, mask non-zero.
- Frame build is combinational in cycle N and registered into cycle N+1.
- Walk threads from rr_ptr upward, modulo THREADS.
- Accept a thread if its mask does not overlap words already claimed in this frame.
- For each accepted thread t and each word w in its mask, set o_w_enables[w][t].
- Without packing (see Configuration), accept only the first eligible thread.
- Frame is issued only if credits > 0 and at least one thread is accepted.
- On issue: o_w_push=1, o_grant = accepted set, rr_ptr = (first accepted + 1) mod THREADS, credits decrement.
- Requester holds i_w_data valid through the grant cycle and drops or renews i_req in the cycle after the grant.
- FSM states:
  - IDLE: no eligible thread.
  - ISSUE: frame issued this cycle.
  - STALL: eligible thread present but credits = 0.
  - Transitions are evaluated every cycle from eligibility and credits. STALL leaves on the first cycle credits > 0.
- Credits:
  - Push and return in the same cycle: count unchanged.
  - Return at CREDITS: count saturates and o_err is set.
- A request with a zero mask is never granted and sets o_err.
- o_err clears only on reset.

## Timing
- Reset values: o_grant=0, o_w_push=0, o_w_enables=0, o_credits=CREDITS, o_err=0, rr_ptr=0, state=IDLE.
- Latency from i_req rising to o_grant/o_w_push: 1 cycle when credits are available.
- o_w_push and o_w_enables are registered and coincident with o_grant.
- A returned credit is usable for an issue decision in the same cycle it arrives; the push follows one cycle later.
- Maximum throughput: one frame per cycle while credits last.
- A reset asserted mid-frame clears every output asynchronously. Any in-flight grant is lost, and the requester must re-request.

## Configuration
- FIFO_WSCHED_PACK_EN:
  - Defined: multiple threads with disjoint masks share one frame.
  - Undefined: exactly one thread per frame, with pure round-robin. Overlap logic is not compiled.

## Structure
- Package fifo_wsched_pkg holds:
  - sched_state_t enum (IDLE, ISSUE, STALL)
  - function CREDIT_W(CREDITS) returning $clog2(CREDITS+1)
- One sub-module, credit_counter:
  - Saturating up/down counter with overflow flag.
  - Reset value CREDITS.

## Test plan
- Reset, then i_req=3'b001 with mask 2'b11 -> next cycle o_grant=001, o_w_push=1, enables word0=001, word1=001, o_credits 2->1.
- PACK_EN, threads 0 and 1 request masks 01 and 10 together -> one push, o_grant=011, word0 enable=001, word1 enable=010.
- Three threads all with mask 11, no credit returns -> grants to threads 0 then 1, then STALL with o_credits=0. A return pulse leads to a grant to thread 2 on the following cycle.
- Push and i_credit_return in the same cycle at o_credits=1 -> o_credits stays 1.
- i_credit_return at o_credits=2 -> o_credits stays 2 and o_err=1 until reset.
- Assert i_rst during ISSUE -> all outputs 0 and o_credits=2 immediately. After release, the held request is granted one cycle after the first clock.

Source files
------------

// File: rtl/fifo_wsched_pkg.sv
// Shared types and helpers for the FIFO write-side scheduler.
package fifo_wsched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        STALL = 2'd2
    } sched_state_t;

    function automatic int CREDIT_W(input int credits);
        return $clog2(credits + 1);
    endfunction

endpackage

// File: rtl/fifo_write_scheduler_credit_counter.sv
// Saturating FIFO-occupancy credit counter; overflow flags a return while already full.
module credit_counter
    import fifo_wsched_pkg::*;
#(
    parameter int CREDITS = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          inc,
    input  logic                          dec,
    output logic [CREDIT_W(CREDITS)-1:0]  count,
    output logic                          overflow
);
    localparam int W = CREDIT_W(CREDITS);
    localparam logic [W-1:0] MAX = W'(CREDITS);

    assign overflow = inc && !dec && (count == MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= MAX;
        end else if (inc && !dec && count != MAX) begin
            count <= count + 1'b1;
        end else if (dec && !inc && count != '0) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/fifo_write_scheduler.sv
// Round-robin write scheduler packing thread word requests into FIFO entries.
// Optional multi-thread packing: define FIFO_WSCHED_PACK_EN.
module fifo_write_scheduler
    import fifo_wsched_pkg::*;
#(
    parameter int WORDS   = 2,
    parameter int THREADS = 3,
    parameter int CREDITS = 2
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [THREADS-1:0]              i_req,
    input  logic [THREADS-1:0][WORDS-1:0]   i_req_mask,
    input  logic                            i_credit_return,
    output logic [THREADS-1:0]              o_grant,
    output logic                            o_w_push,
    output logic [WORDS-1:0][THREADS-1:0]   o_w_enables,
    output logic [CREDIT_W(CREDITS)-1:0]    o_credits,
    output logic                            o_err
);
    localparam int PTR_W = (THREADS > 1) ? $clog2(THREADS) : 1;

    sched_state_t                   state, state_next;
    logic [PTR_W-1:0]               rr_ptr, rr_next;
    logic [PTR_W-1:0]               idx, first;
    logic [THREADS-1:0]             grant_p0;
    logic [WORDS-1:0][THREADS-1:0]  en_p0;
    logic                           found, zero_req, credit_ok, issue, overflow;
    int                             t;
`ifdef FIFO_WSCHED_PACK_EN
    logic [WORDS-1:0]               claimed;
`endif

    // A credit returned this cycle may already back this cycle's issue.
    assign credit_ok = (o_credits != '0) || i_credit_return;
    assign issue     = found && credit_ok;

    always_comb begin
        grant_p0 = '0;
        en_p0    = '0;
        first    = '0;
        found    = 1'b0;
        zero_req = 1'b0;
        t        = 0;
        idx      = '0;
`ifdef FIFO_WSCHED_PACK_EN
        claimed  = '0;
`endif
        for (int k = 0; k < THREADS; k++) begin
            t = int'(rr_ptr) + k;
            if (t >= THREADS) t = t - THREADS;
            idx = PTR_W'(t);
            if (i_req[idx] && i_req_mask[idx] == '0) zero_req = 1'b1;
            if (i_req[idx] && !o_grant[idx] && i_req_mask[idx] != '0) begin
`ifdef FIFO_WSCHED_PACK_EN
                if ((i_req_mask[idx] & claimed) == '0) begin
                    claimed = claimed | i_req_mask[idx];
`else
                if (!found) begin
`endif
                    grant_p0[idx] = 1'b1;
                    for (int w = 0; w < WORDS; w++) begin
                        en_p0[w][idx] = i_req_mask[idx][w];
                    end
                    if (!found) first = idx;
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_next = IDLE;
        rr_next    = rr_ptr;
        if (issue) begin
            state_next = ISSUE;
            rr_next    = (first == PTR_W'(THREADS - 1)) ? '0 : first + 1'b1;
        end else if (found) begin
            state_next = STALL;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
        end else begin
            state  <= state_next;
            rr_ptr <= rr_next;
        end
    end

    // Frame registered: grant, push and enables appear together one cycle later.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_grant     <= '0;
            o_w_enables <= '0;
            o_err       <= 1'b0;
        end else begin
            o_grant     <= issue ? grant_p0 : '0;
            o_w_enables <= issue ? en_p0 : '0;
            o_err       <= o_err | zero_req | overflow;
        end
    end

    assign o_w_push = (state == ISSUE);

    credit_counter #(
        .CREDITS (CREDITS)
    ) u_credits (
        .clk      (i_clk),
        .rst      (i_rst),
        .inc      (i_credit_return),
        .dec      (issue),
        .count    (o_credits),
        .overflow (overflow)
    );

endmodule
